// File: rtl/calc_rx_parser.sv
// Assembles "DD op DD" ASCII expressions from the UART byte stream into binary operands and an opcode.
// Optional terminal echo of accepted bytes is enabled by defining CALC_RX_PARSER_ECHO_EN.
module calc_rx_parser #(
  parameter int DIGITS = 2,
  parameter int OPW    = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [7:0]     rx_data,
  input  logic           rx_valid,
  output logic [OPW-1:0] op_a,
  output logic [OPW-1:0] op_b,
  output logic [1:0]     opcode,
  output logic           out_valid,
  input  logic           out_ready,
  output logic           err,
  output logic           overrun
`ifdef CALC_RX_PARSER_ECHO_EN
  ,
  output logic [7:0]     echo_data,
  output logic           echo_valid
`endif
);

  localparam int CW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  typedef enum logic [1:0] {GET_A, GET_OP, GET_B, HOLD} state_t;

  function automatic logic is_digit(input logic [7:0] b);
    return (b >= 8'h30) && (b <= 8'h39);
  endfunction

  // Returns {recognised, code}
  function automatic logic [2:0] op_decode(input logic [7:0] b);
    case (b)
      8'h2B:   return 3'b100;
      8'h2D:   return 3'b101;
      8'h2A:   return 3'b110;
      8'h2F:   return 3'b111;
      default: return 3'b000;
    endcase
  endfunction

  state_t           state_r, state_s;
  logic [CW-1:0]    cnt_r, cnt_s;
  logic [OPW-1:0]   acc_a_r, acc_a_s, acc_b_r, acc_b_s;
  logic [OPW-1:0]   op_a_r, op_a_s, op_b_r, op_b_s;
  logic [1:0]       op_lat_r, op_lat_s, opcode_r, opcode_s;
  logic             out_valid_r, out_valid_s;
  logic             err_r, err_s;
  logic             overrun_r, overrun_s;
  logic [OPW-1:0]   digit_s;
  logic [2:0]       opdec_s;
  logic             last_s;

  assign digit_s = OPW'(rx_data - 8'h30);
  assign opdec_s = op_decode(rx_data);
  assign last_s  = (cnt_r == CW'(DIGITS - 1));

  // Next-state and datapath decode for the expression parser
  always_comb begin
    state_s     = state_r;
    cnt_s       = cnt_r;
    acc_a_s     = acc_a_r;
    acc_b_s     = acc_b_r;
    op_a_s      = op_a_r;
    op_b_s      = op_b_r;
    op_lat_s    = op_lat_r;
    opcode_s    = opcode_r;
    out_valid_s = out_valid_r;
    err_s       = 1'b0;
    overrun_s   = overrun_r;
    case (state_r)
      GET_A: begin
        if (rx_valid && is_digit(rx_data)) begin
          acc_a_s = acc_a_r * OPW'(4'd10) + digit_s;
          if (last_s) begin
            cnt_s   = '0;
            state_s = GET_OP;
          end else begin
            cnt_s = cnt_r + CW'(1'b1);
          end
        end else if (rx_valid) begin
          err_s   = 1'b1;
          acc_a_s = '0;
          cnt_s   = '0;
        end else begin
          state_s = GET_A;
        end
      end
      GET_OP: begin
        if (rx_valid && opdec_s[2]) begin
          op_lat_s = opdec_s[1:0];
          state_s  = GET_B;
        end else if (rx_valid) begin
          err_s   = 1'b1;
          acc_a_s = '0;
          cnt_s   = '0;
          state_s = GET_A;
        end else begin
          state_s = GET_OP;
        end
      end
      GET_B: begin
        if (rx_valid && is_digit(rx_data)) begin
          acc_b_s = acc_b_r * OPW'(4'd10) + digit_s;
          if (last_s) begin
            cnt_s       = '0;
            op_a_s      = acc_a_r;
            op_b_s      = acc_b_s;
            opcode_s    = op_lat_r;
            out_valid_s = 1'b1;
            state_s     = HOLD;
          end else begin
            cnt_s = cnt_r + CW'(1'b1);
          end
        end else if (rx_valid) begin
          err_s   = 1'b1;
          acc_a_s = '0;
          acc_b_s = '0;
          cnt_s   = '0;
          state_s = GET_A;
        end else begin
          state_s = GET_B;
        end
      end
      HOLD: begin
        // Any byte arriving while the tuple is held is lost, handshake cycle included
        if (rx_valid) begin
          overrun_s = 1'b1;
        end else begin
          overrun_s = overrun_r;
        end
        if (out_ready) begin
          out_valid_s = 1'b0;
          acc_a_s     = '0;
          acc_b_s     = '0;
          cnt_s       = '0;
          state_s     = GET_A;
        end else begin
          state_s = HOLD;
        end
      end
      default: begin
        state_s     = GET_A;
        cnt_s       = '0;
        acc_a_s     = '0;
        acc_b_s     = '0;
        out_valid_s = 1'b0;
      end
    endcase
  end

  // Parser state and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= GET_A;
      cnt_r       <= '0;
      acc_a_r     <= '0;
      acc_b_r     <= '0;
      op_a_r      <= '0;
      op_b_r      <= '0;
      op_lat_r    <= 2'b00;
      opcode_r    <= 2'b00;
      out_valid_r <= 1'b0;
      err_r       <= 1'b0;
      overrun_r   <= 1'b0;
    end else begin
      state_r     <= state_s;
      cnt_r       <= cnt_s;
      acc_a_r     <= acc_a_s;
      acc_b_r     <= acc_b_s;
      op_a_r      <= op_a_s;
      op_b_r      <= op_b_s;
      op_lat_r    <= op_lat_s;
      opcode_r    <= opcode_s;
      out_valid_r <= out_valid_s;
      err_r       <= err_s;
      overrun_r   <= overrun_s;
    end
  end

  assign op_a      = op_a_r;
  assign op_b      = op_b_r;
  assign opcode    = opcode_r;
  assign out_valid = out_valid_r;
  assign err       = err_r;
  assign overrun   = overrun_r;

`ifdef CALC_RX_PARSER_ECHO_EN
  logic       accept_s;
  logic [7:0] echo_data_r;
  logic       echo_valid_r;

  assign accept_s = rx_valid && (state_r != HOLD) && !err_s;

  // Echo register: one-cycle copy of every accepted byte
  always_ff @(posedge clk) begin
    if (rst) begin
      echo_data_r  <= 8'h00;
      echo_valid_r <= 1'b0;
    end else begin
      echo_valid_r <= accept_s;
      echo_data_r  <= accept_s ? rx_data : echo_data_r;
    end
  end

  assign echo_data  = echo_data_r;
  assign echo_valid = echo_valid_r;
`endif

endmodule

// File: tb/tb_calc_rx_parser.sv
// Scoreboard bench for calc_rx_parser: directed expressions plus randomized byte streams checked
// against a queue-based expression model.
module tb_calc_rx_parser;
  localparam int DIG = 2;
  localparam int OPW = 8;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [7:0]     rx_data = 8'h00;
  logic           rx_valid = 1'b0;
  logic           out_ready = 1'b0;
  logic [OPW-1:0] op_a, op_b;
  logic [1:0]     opcode;
  logic           out_valid, err, overrun;
`ifdef CALC_RX_PARSER_ECHO_EN
  logic [7:0]     echo_data;
  logic           echo_valid;
`endif

  calc_rx_parser #(.DIGITS(DIG), .OPW(OPW)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
    .op_a(op_a), .op_b(op_b), .opcode(opcode), .out_valid(out_valid),
    .out_ready(out_ready), .err(err), .overrun(overrun)
`ifdef CALC_RX_PARSER_ECHO_EN
    , .echo_data(echo_data), .echo_valid(echo_valid)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [OPW-1:0] a;
    logic [OPW-1:0] b;
    logic [1:0]     op;
  } tup_t;

  int   checks = 0;
  int   errors = 0;
  tup_t exq[$];
  byte unsigned expr_q[$];
  bit   m_hold = 0, m_ovr = 0, m_err = 0, m_echo = 0;
  logic [7:0] m_echo_d = 8'h00;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int op_of(input logic [7:0] b);
    case (b)
      8'h2B:   return 0;
      8'h2D:   return 1;
      8'h2A:   return 2;
      8'h2F:   return 3;
      default: return -1;
    endcase
  endfunction

  // Reference model: the expression is the list of accepted characters so far
  task automatic model(input bit r, input bit v, input logic [7:0] d, input bit rdy);
    int pos;
    bit ok;
    tup_t t;
    m_err  = 0;
    m_echo = 0;
    if (r) begin
      expr_q.delete();
      exq.delete();
      m_hold = 0;
      m_ovr  = 0;
    end else if (m_hold) begin
      if (v) m_ovr = 1;
      if (rdy) m_hold = 0;
    end else if (v) begin
      pos = expr_q.size();
      ok  = (pos == DIG) ? (op_of(d) >= 0) : (d >= 8'h30 && d <= 8'h39);
      if (ok) begin
        expr_q.push_back(d);
        m_echo   = 1;
        m_echo_d = d;
        if (expr_q.size() == 2 * DIG + 1) begin
          int a, b;
          a = 0;
          b = 0;
          for (int i = 0; i < DIG; i++) begin
            a = a * 10 + (expr_q[i] - 48);
            b = b * 10 + (expr_q[DIG + 1 + i] - 48);
          end
          t.a  = OPW'(a);
          t.b  = OPW'(b);
          t.op = 2'(op_of(expr_q[DIG]));
          exq.push_back(t);
          expr_q.delete();
          m_hold = 1;
        end
      end else begin
        m_err = 1;
        expr_q.delete();
      end
    end
  endtask

  task automatic step(input bit r, input bit v, input logic [7:0] d, input bit rdy);
    rst       = r;
    rx_valid  = v;
    rx_data   = d;
    out_ready = rdy;
    model(r, v, d, rdy);
    @(posedge clk);
    #2;
    chk("err", 32'(err), 32'(m_err));
    chk("overrun", 32'(overrun), 32'(m_ovr));
    chk("out_valid", 32'(out_valid), 32'(m_hold));
`ifdef CALC_RX_PARSER_ECHO_EN
    chk("echo_valid", 32'(echo_valid), 32'(m_echo));
    if (m_echo) chk("echo_data", 32'(echo_data), 32'(m_echo_d));
`endif
  endtask

  task automatic send_expr(input string s, input int gap, input bit rdy);
    for (int i = 0; i < s.len(); i++) begin
      step(1'b0, 1'b1, s[i], rdy);
      repeat (gap) step(1'b0, 1'b0, 8'h00, rdy);
    end
  endtask

  // Monitor: compares the held tuple every cycle and retires it on handshake
  always @(negedge clk) begin
    if (!rst && out_valid) begin
      if (exq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL tuple_unexpected actual=%0d,%0d,%0d required=none", op_a, op_b, opcode);
      end else begin
        chk("op_a", 32'(op_a), 32'(exq[0].a));
        chk("op_b", 32'(op_b), 32'(exq[0].b));
        chk("opcode", 32'(opcode), 32'(exq[0].op));
        if (out_ready) void'(exq.pop_front());
      end
    end
  end

  initial begin
    string ops = "+-*/";
    logic [7:0] c;
    step(1'b1, 1'b0, 8'h00, 1'b0);
    step(1'b1, 1'b0, 8'h00, 1'b0);
    chk("rst_op_a", 32'(op_a), 32'd0);
    chk("rst_op_b", 32'(op_b), 32'd0);
    chk("rst_opcode", 32'(opcode), 32'd0);

    send_expr("87*93", 39, 1'b1);
    repeat (3) step(1'b0, 1'b0, 8'h00, 1'b1);

    send_expr("12+34", 2, 1'b0);
    step(1'b0, 1'b1, 8'h35, 1'b0);
    repeat (100) step(1'b0, 1'b0, 8'h00, 1'b0);
    step(1'b0, 1'b0, 8'h00, 1'b1);
    chk("overrun_sticky", 32'(overrun), 32'd1);
    send_expr("99/01", 2, 1'b1);
    repeat (2) step(1'b0, 1'b0, 8'h00, 1'b1);

    send_expr("8x", 1, 1'b1);
    send_expr("05-07", 1, 1'b1);
    send_expr("43#", 1, 1'b1);
    send_expr("10*10", 1, 1'b1);
    repeat (2) step(1'b0, 1'b0, 8'h00, 1'b1);

    send_expr("87*9", 1, 1'b1);
    step(1'b1, 1'b1, 8'h33, 1'b1);
    send_expr("11+22", 1, 1'b1);
    repeat (2) step(1'b0, 1'b0, 8'h00, 1'b1);
    send_expr("8x7", 0, 1'b1);
    step(1'b1, 1'b0, 8'h00, 1'b1);

    for (int n = 0; n < 60; n++) begin
      for (int k = 0; k < 2 * DIG + 1; k++) begin
        if (k == DIG) c = ops[$urandom_range(0, 3)];
        else c = 8'h30 + 8'($urandom_range(0, 9));
        if ($urandom_range(0, 11) == 0) c = 8'($urandom_range(0, 255));
        step(($urandom_range(0, 39) == 0), 1'b1, c, ($urandom_range(0, 3) != 0));
        repeat ($urandom_range(0, 3)) step(1'b0, 1'b0, 8'h00, ($urandom_range(0, 3) != 0));
      end
    end

    repeat (5) step(1'b0, 1'b0, 8'h00, 1'b1);
    chk("scoreboard_drained", 32'(exq.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
